snake_body_seq: RTL and testbench
=================================

// Module: snake_body_seq
// PURPOSE
//  Owns the snake body store: a ring buffer of (x,y) segments, index 0 = head.
//  Per game tick, the top-level FSM hands it the new head and a grow flag. The block:
//   - serially scans the body for a self-collision;
//   - pushes the new head, and pops the tail unless growing;
//   - reports hit/done.
//  A registered random-access read port serves the VGA renderer.
// PARAMETERS
//  XW        7   x coordinate width
//  YW        7   y coordinate width
//  MAX_LEN   64  max segments held (power of 2)
//  AW        6   pointer/index width, = log2(MAX_LEN)
//  INIT_LEN  3   segments loaded by i_Init (2..MAX_LEN)
// PORTS
//  i_Clk      in   1       clock, all logic on rising edge
//  i_Rst      in   1       synchronous reset, active-high
//  i_Init     in   1       pulse: load initial snake from i_Head_x/y
//  i_Start    in   1       pulse: perform one tick step with i_Head_x/y, i_Grow
//  i_Head_x   in   XW      new head x (sampled on i_Init/i_Start accept)
//  i_Head_y   in   YW      new head y
//  i_Grow     in   1       step extends length by 1 (sampled with i_Start)
//  i_Rd_idx   in   AW      read index, 0 = head, Len-1 = tail
//  o_Rd_x     out  XW      segment x at i_Rd_idx, 1-cycle latency; 0 if idx>=Len
//  o_Rd_y     out  YW      segment y, same rules
//  o_Busy     out  1       1 in any state except IDLE
//  o_Done     out  1       1-cycle pulse: step or init finished
//  o_Hit      out  1       collision result; valid with o_Done, held until next accept
//  o_Len      out  AW+1    current segment count
//  o_Full     out  1       o_Len == MAX_LEN
// BEHAVIOUR
//  Reset: state IDLE; Len=0; head/tail ptr=0; all outputs 0. Array contents don't care.
//  States: IDLE, INIT, SCAN, UPDATE, DONE.
//  IDLE:
//   - i_Init has priority: latch head, clear o_Hit, go INIT.
//   - else i_Start: latch head and grow, clear o_Hit, k=0, go SCAN.
//  INIT:
//   - writes segment k = (Hx-k, Hy), k = 0..INIT_LEN-1, one per cycle.
//   - then Len=INIT_LEN, go DONE.
//  SCAN:
//   - compares body[k] with the latched head, one segment per cycle, k = 0..Len-1.
//   - Tail (k=Len-1) is masked when eff_grow=0: the tail vacates this tick.
//   - Match -> o_Hit=1, go DONE immediately; body, Len and ptrs unchanged.
//   - k==Len-1 without a match -> UPDATE.
//   - Len==0 -> UPDATE directly.
//  eff_grow = i_Grow & ~o_Full: grow at full length saturates to a plain move.
//  UPDATE (1 cycle):
//   - head ptr -1 mod MAX_LEN; write the new head there.
//   - eff_grow=1: Len+1.
//   - eff_grow=0 and Len>0: tail ptr -1 (pop).
//   - Len==0: Len becomes 1.
//   - Then go DONE.
//  DONE: o_Done=1 for this cycle only; next cycle IDLE.
//  Latency: i_Start accepted at edge T (clean step) -> o_Done high in cycle T+Len+2.
//   A hit at index k gives o_Done at T+k+2.
//  Busy rules:
//   - i_Start while o_Busy: ignored, not queued.
//   - i_Init while o_Busy: aborts the step (no partial update), restarts INIT.
//  Mid-operation i_Rst: returns to reset state in one cycle; no o_Done.
//  Read port:
//   - registered; uses the array/ptr state before the same edge's write.
//   - address = head ptr + idx mod MAX_LEN.
//   - idx >= Len returns (0,0): coordinate 0 is the null/wall value.
//  Not this block's job: wall/border collision (caller checks x/y bounds).
//  Coordinate subtraction in INIT wraps mod 2^XW; caller guarantees Hx >= INIT_LEN.
// TESTING
//  1. Init, head (30,40) -> o_Done; Len=3; idx0..2 = (30,40),(29,40),(28,40); idx3=(0,0).
//  2. Start (31,40) Grow=0 -> o_Done 5 cycles after accept; Hit=0; Len=3;
//     idx0=(31,40), idx2=(29,40).
//  3. Start (32,40) Grow=1 -> Hit=0; Len=4; tail idx3=(29,40).
//  4. Body (30,40),(30,41),(31,41),(31,40): start onto idx2 (31,41) -> Hit=1,
//     o_Done at T+4; Len and contents unchanged.
//     Start onto tail (31,40) with Grow=0 -> Hit=0; with Grow=1 -> Hit=1.
//  5. MAX_LEN=4, AW=2 at Len=4: Start Grow=1 -> Len stays 4, o_Full=1, tail popped.
//     Repeat with enough steps to wrap the pointers.
//  6. i_Start while busy -> ignored.
//     i_Init mid-SCAN -> INIT result only.
//     i_Rst mid-SCAN -> Len=0, outputs 0, no o_Done.

Source files
------------

// File: rtl/snake_body_seq_if.sv
// Handshake, step control and render-read bundle between the game FSM and the snake body store.
interface snake_body_seq_if #(
    parameter int XW = 7,
    parameter int YW = 7,
    parameter int AW = 6
);
    logic          i_Init;
    logic          i_Start;
    logic [XW-1:0] i_Head_x;
    logic [YW-1:0] i_Head_y;
    logic          i_Grow;
    logic [AW-1:0] i_Rd_idx;
    logic [XW-1:0] o_Rd_x;
    logic [YW-1:0] o_Rd_y;
    logic          o_Busy;
    logic          o_Done;
    logic          o_Hit;
    logic [AW:0]   o_Len;
    logic          o_Full;

    modport master (
        output i_Init, i_Start, i_Head_x, i_Head_y, i_Grow, i_Rd_idx,
        input  o_Rd_x, o_Rd_y, o_Busy, o_Done, o_Hit, o_Len, o_Full
    );
    modport slave (
        input  i_Init, i_Start, i_Head_x, i_Head_y, i_Grow, i_Rd_idx,
        output o_Rd_x, o_Rd_y, o_Busy, o_Done, o_Hit, o_Len, o_Full
    );
endinterface

// File: rtl/snake_body_seq.sv
// Snake body ring buffer: serial self-collision scan, head push / tail pop per tick,
// and a registered random-access read port for the renderer.
module snake_body_seq #(
    parameter int XW       = 7,
    parameter int YW       = 7,
    parameter int MAX_LEN  = 64,
    parameter int AW       = 6,
    parameter int INIT_LEN = 3
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    snake_body_seq_if.slave  bus
);
    localparam int DW = XW + YW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_SCAN   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [AW:0]   LEN_MAX   = (AW+1)'(MAX_LEN);
    localparam logic [AW:0]   LEN_INIT  = (AW+1)'(INIT_LEN);
    localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] TAIL_INIT = AW'(INIT_LEN - 1);

    logic [DW-1:0]   mem [MAX_LEN];

    logic [2:0]      state_reg;
    logic [AW:0]     len_reg;
    logic [AW-1:0]   head_ptr_reg;
    logic [AW-1:0]   tail_ptr_reg;
    logic [AW:0]     k_reg;
    logic [XW-1:0]   hx_reg;
    logic [YW-1:0]   hy_reg;
    logic            grow_reg;
    logic            hit_reg;
    logic            scan_vld_reg;
    logic [AW-1:0]   scan_addr_reg;
    logic [DW-1:0]   scan_q_reg;
    logic [DW-1:0]   rd_q_reg;
    logic            rd_vld_reg;

    logic            full;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [AW-1:0]   scan_addr;
    logic [AW-1:0]   rd_addr;
    logic            scan_match;
    logic            scan_last;

    assign full      = (len_reg == LEN_MAX);
    assign scan_addr = head_ptr_reg + k_reg[AW-1:0];
    assign rd_addr   = head_ptr_reg + bus.i_Rd_idx;
    assign scan_last = (scan_addr_reg == tail_ptr_reg);
    // The tail slot is vacated this tick unless the snake grows, so it cannot be hit.
    assign scan_match = (scan_q_reg == {hx_reg, hy_reg}) && !(scan_last && !grow_reg);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state_reg == S_INIT) begin
            wr_en   = 1'b1;
            wr_addr = k_reg[AW-1:0];
            wr_data = {hx_reg - XW'(k_reg), hy_reg};
        end else if (state_reg == S_UPDATE && !bus.i_Init) begin
            wr_en   = 1'b1;
            wr_addr = head_ptr_reg - PTR_ONE;
            wr_data = {hx_reg, hy_reg};
        end
    end

    always_ff @(posedge i_Clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q_reg   <= mem[rd_addr];
        scan_q_reg <= mem[scan_addr];
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            head_ptr_reg  <= '0;
            tail_ptr_reg  <= '0;
            k_reg         <= '0;
            hx_reg        <= '0;
            hy_reg        <= '0;
            grow_reg      <= 1'b0;
            hit_reg       <= 1'b0;
            scan_vld_reg  <= 1'b0;
            scan_addr_reg <= '0;
            rd_vld_reg    <= 1'b0;
        end else begin
            rd_vld_reg   <= ({1'b0, bus.i_Rd_idx} < len_reg);
            scan_vld_reg <= 1'b0;
            if (bus.i_Init) begin
                hx_reg       <= bus.i_Head_x;
                hy_reg       <= bus.i_Head_y;
                hit_reg      <= 1'b0;
                head_ptr_reg <= '0;
                k_reg        <= '0;
                state_reg    <= S_INIT;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.i_Start) begin
                            hx_reg    <= bus.i_Head_x;
                            hy_reg    <= bus.i_Head_y;
                            grow_reg  <= bus.i_Grow & ~full;
                            hit_reg   <= 1'b0;
                            k_reg     <= '0;
                            state_reg <= S_SCAN;
                        end
                    end
                    S_INIT: begin
                        k_reg <= k_reg + LEN_ONE;
                        if (k_reg == LEN_INIT - LEN_ONE) begin
                            len_reg      <= LEN_INIT;
                            tail_ptr_reg <= TAIL_INIT;
                            state_reg    <= S_DONE;
                        end
                    end
                    S_SCAN: begin
                        if (len_reg == '0) begin
                            state_reg <= S_UPDATE;
                        end else begin
                            // Read is issued one cycle ahead of its compare.
                            if (k_reg < len_reg) begin
                                k_reg         <= k_reg + LEN_ONE;
                                scan_vld_reg  <= 1'b1;
                                scan_addr_reg <= scan_addr;
                            end
                            if (scan_vld_reg) begin
                                if (scan_match) begin
                                    hit_reg   <= 1'b1;
                                    state_reg <= S_DONE;
                                end else if (scan_last) begin
                                    state_reg <= S_UPDATE;
                                end
                            end
                        end
                    end
                    S_UPDATE: begin
                        head_ptr_reg <= head_ptr_reg - PTR_ONE;
                        if (len_reg == '0) begin
                            len_reg      <= LEN_ONE;
                            tail_ptr_reg <= head_ptr_reg - PTR_ONE;
                        end else if (grow_reg) begin
                            len_reg <= len_reg + LEN_ONE;
                        end else begin
                            tail_ptr_reg <= tail_ptr_reg - PTR_ONE;
                        end
                        state_reg <= S_DONE;
                    end
                    S_DONE:  state_reg <= S_IDLE;
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_Rd_x = rd_vld_reg ? rd_q_reg[DW-1:YW] : '0;
    assign bus.o_Rd_y = rd_vld_reg ? rd_q_reg[YW-1:0]  : '0;
    assign bus.o_Busy = (state_reg != S_IDLE);
    assign bus.o_Done = (state_reg == S_DONE);
    assign bus.o_Hit  = hit_reg;
    assign bus.o_Len  = len_reg;
    assign bus.o_Full = full;
endmodule

// File: tb/tb_snake_body_seq.sv
// Scoreboard bench for snake_body_seq: a 64-deep and a 4-deep instance share stimulus,
// the selected one is checked against a queue model of the body.
module tb_snake_body_seq;
    localparam int XW = 7;
    localparam int YW = 7;
    localparam int INIT_LEN = 3;

    typedef logic [XW+YW-1:0] seg_t;
    typedef struct {
        logic hit;
        int   len;
        int   lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init = 1'b0;
    logic          start = 1'b0;
    logic          grow = 1'b0;
    logic [XW-1:0] hx = '0;
    logic [YW-1:0] hy = '0;
    logic [5:0]    rd_idx = '0;
    logic          sel = 1'b0;

    always #5 clk = ~clk;

    snake_body_seq_if #(.XW(XW), .YW(YW), .AW(6)) bus_a ();
    snake_body_seq_if #(.XW(XW), .YW(YW), .AW(2)) bus_b ();

    assign bus_a.i_Init   = init;
    assign bus_a.i_Start  = start;
    assign bus_a.i_Grow   = grow;
    assign bus_a.i_Head_x = hx;
    assign bus_a.i_Head_y = hy;
    assign bus_a.i_Rd_idx = rd_idx;
    assign bus_b.i_Init   = init;
    assign bus_b.i_Start  = start;
    assign bus_b.i_Grow   = grow;
    assign bus_b.i_Head_x = hx;
    assign bus_b.i_Head_y = hy;
    assign bus_b.i_Rd_idx = rd_idx[1:0];

    snake_body_seq #(.XW(XW), .YW(YW), .MAX_LEN(64), .AW(6), .INIT_LEN(INIT_LEN)) dut_a (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus_a)
    );
    snake_body_seq #(.XW(XW), .YW(YW), .MAX_LEN(4), .AW(2), .INIT_LEN(INIT_LEN)) dut_b (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus_b)
    );

    seg_t       rd_xy;
    logic       busy, done, hit, full;
    logic [6:0] len;

    always_comb begin
        rd_xy = '0; busy = 1'b0; done = 1'b0; hit = 1'b0; full = 1'b0; len = '0;
        if (sel) begin
            rd_xy = {bus_b.o_Rd_x, bus_b.o_Rd_y};
            busy  = bus_b.o_Busy; done = bus_b.o_Done; hit = bus_b.o_Hit;
            full  = bus_b.o_Full; len = 7'(bus_b.o_Len);
        end else begin
            rd_xy = {bus_a.o_Rd_x, bus_a.o_Rd_y};
            busy  = bus_a.o_Busy; done = bus_a.o_Done; hit = bus_a.o_Hit;
            full  = bus_a.o_Full; len = bus_a.o_Len;
        end
    end

    seg_t body[$];
    exp_t exp_q[$];
    seg_t rd_q[$];
    int   max_len = 64;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic model_init(input logic [XW-1:0] x, input logic [YW-1:0] y);
        exp_t e;
        body.delete();
        for (int k = 0; k < INIT_LEN; k++) body.push_back({XW'(x - XW'(k)), y});
        e.hit = 1'b0; e.len = INIT_LEN; e.lat = INIT_LEN;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic g);
        exp_t e;
        int   n = body.size();
        logic ge = g && (n < max_len);
        int   hitk = -1;
        for (int k = 0; k < n; k++) begin
            if (body[k] == {x, y} && !(k == n - 1 && !ge)) begin
                hitk = k;
                break;
            end
        end
        if (hitk >= 0) begin
            e.hit = 1'b1; e.len = n; e.lat = hitk + 2;
        end else begin
            body.push_front({x, y});
            if (!ge && n > 0) void'(body.pop_back());
            e.hit = 1'b0; e.len = body.size(); e.lat = n + 2;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic is_init, input logic [XW-1:0] x, input logic [YW-1:0] y,
                         input logic g);
        @(negedge clk);
        hx = x; hy = y; grow = g;
        if (is_init) init = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0; start = 1'b0;
    endtask

    // cyc0 = edges already consumed since the accept edge
    task automatic wait_done(input string tag, input int cyc0);
        exp_t e;
        int   cyc = cyc0;
        logic seen = 1'b0;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        while (!seen && cyc < 300) begin
            @(posedge clk); cyc++;
            @(negedge clk); seen = done;
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, cyc, e.lat);
        chk({tag, "_hit"}, 32'(hit), 32'(e.hit));
        chk({tag, "_len"}, 32'(len), e.len);
        chk({tag, "_full"}, 32'(full), 32'(e.len == max_len));
        $display("txn %s: hit=%0d len=%0d latency=%0d", tag, hit, len, cyc);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'(hit), 32'(e.hit));
    endtask

    task automatic step(input string tag, input logic [XW-1:0] x, input logic [YW-1:0] y,
                        input logic g);
        model_step(x, y, g);
        drive(1'b0, x, y, g);
        wait_done(tag, 0);
    endtask

    task automatic do_init(input string tag, input logic [XW-1:0] x, input logic [YW-1:0] y);
        model_init(x, y);
        drive(1'b1, x, y, 1'b0);
        wait_done(tag, 0);
    endtask

    task automatic read_body(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            rd_q.push_back((i < body.size()) ? body[i] : '0);
            @(negedge clk);
            rd_idx = 6'(i);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s_rd%0d", tag, i), 32'(rd_xy), 32'(rd_q.pop_front()));
        end
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk(tag, cnt, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_len", 32'(len), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_rd", 32'(rd_xy), 0);

        // Empty body: scan skipped, length becomes one
        step("empty_step", 7'd5, 7'd5, 1'b0);
        read_body("empty", 2);

        do_init("init", 7'd30, 7'd40);
        read_body("init", 4);
        step("move", 7'd31, 7'd40, 1'b0);
        read_body("move", 3);
        step("grow", 7'd32, 7'd40, 1'b1);
        read_body("grow", 4);

        // Build the square body (30,40),(30,41),(31,41),(31,40)
        do_init("init2", 7'd31, 7'd40);
        step("sq1", 7'd31, 7'd41, 1'b0);
        step("sq2", 7'd30, 7'd41, 1'b1);
        step("tail_move", 7'd30, 7'd40, 1'b0);
        read_body("square", 4);
        step("hit_mid", 7'd31, 7'd41, 1'b0);
        read_body("after_hit", 4);
        step("hit_tail_grow", 7'd31, 7'd40, 1'b1);
        step("tail_nogrow", 7'd31, 7'd40, 1'b0);
        read_body("tail_move", 4);

        // Start while busy is dropped
        model_step(7'd32, 7'd40, 1'b0);
        drive(1'b0, 7'd32, 7'd40, 1'b0);
        drive(1'b0, 7'd31, 7'd40, 1'b0);
        wait_done("busy_start", 1);
        expect_quiet("busy_start_noq", 8);
        read_body("busy_start", 4);

        // Init aborts a step in SCAN
        drive(1'b0, 7'd33, 7'd40, 1'b0);
        @(posedge clk);
        model_init(7'd50, 7'd10);
        drive(1'b1, 7'd50, 7'd10, 1'b0);
        wait_done("init_abort", 0);
        expect_quiet("init_abort_quiet", 8);
        read_body("init_abort", 4);

        // Reset mid-SCAN
        drive(1'b0, 7'd51, 7'd10, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        body.delete();
        chk("mrst_len", 32'(len), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_hit", 32'(hit), 0);
        chk("mrst_rd", 32'(rd_xy), 0);
        expect_quiet("mrst_quiet", 10);

        // Small instance: saturating growth and pointer wrap
        sel = 1'b1;
        max_len = 4;
        do_init("s_init", 7'd10, 7'd5);
        for (int i = 0; i < 12; i++) begin
            step($sformatf("s_grow%0d", i), 7'(11 + i), 7'd5, 1'b1);
        end
        read_body("s_wrap", 4);
        step("s_hit", 7'd21, 7'd5, 1'b1);
        read_body("s_final", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
